// File: rtl/ats_pkg.sv
// Shared ATS21 constants and types: alarm/clock counts and the alarm ID type.
package ats_pkg;

    localparam int NUM_ALARMS  = 24;
    localparam int NUM_CLOCKS  = 4;
    localparam int CLOCK_WIDTH = 32;
    localparam int ALARM_ID_W  = $clog2(NUM_ALARMS);

    typedef logic [ALARM_ID_W-1:0] alarm_id_t;

endpackage

// File: rtl/ats_sync_fifo.sv
// Single-clock FIFO, power-of-two depth, one push and one pop per cycle.
// Pointers carry one extra bit so full and empty are distinguishable.
module ats_sync_fifo #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                   (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

    // A push at full is accepted only when the head leaves in the same cycle.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    // Head reads as zero when empty so stale entries never leak out.
    assign rdata = empty ? '0 : mem_q[rd_ptr_q[ADDR_W-1:0]];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[ADDR_W-1:0]] = wdata;
            wr_ptr_d = wr_ptr_q + (ADDR_W+1)'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + (ADDR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            mem_q    <= '{default: '0};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/ats_alarm_event_queue.sv
// Turns ATS21 alarm finish levels into sticky pending bits, then queues their IDs
// lowest-ID-first into a FIFO drained by a valid/pop handshake.
module ats_alarm_event_queue #(
    parameter int NUM_ALARMS = ats_pkg::NUM_ALARMS,
    parameter int FIFO_DEPTH = 8,
    parameter int ID_W       = $clog2(NUM_ALARMS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_ALARMS-1:0]         alarm_finished,
    input  logic [NUM_ALARMS-1:0]         alarm_mask,
    output logic                          evt_valid,
    output logic [ID_W-1:0]               evt_id,
    input  logic                          evt_pop,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic [NUM_ALARMS-1:0]         pending,
    output logic                          overflow,
    input  logic                          clr_overflow
);

    logic [NUM_ALARMS-1:0] fin_q, fin_d;
    logic [NUM_ALARMS-1:0] pending_q, pending_d;
    logic                  overflow_q, overflow_d;
    logic [NUM_ALARMS-1:0] edge_det;
    logic [NUM_ALARMS-1:0] grant;
    logic [ID_W-1:0]       grant_id;
    logic                  space_avail;
    logic                  push;
    logic                  fifo_full;
    logic                  fifo_empty;

    // Descending scan so the lowest set index is the one left standing.
    function automatic logic [ID_W-1:0] lowest_id(input logic [NUM_ALARMS-1:0] v);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (v[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    always_comb begin
        fin_d       = alarm_finished;
        edge_det    = alarm_finished & ~fin_q & ~alarm_mask;
        space_avail = ~fifo_full | (evt_pop & ~fifo_empty);
        grant_id    = lowest_id(pending_q);
        push        = (|pending_q) & space_avail;
        grant       = push ? (NUM_ALARMS'(1) << grant_id) : '0;
        // A fresh edge on the granted bit re-arms it, so that event survives.
        pending_d   = (pending_q & ~grant) | edge_det;
        overflow_d  = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (|(edge_det & pending_q & ~grant)) overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fin_q      <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            fin_q      <= fin_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    ats_sync_fifo #(
        .WIDTH (ID_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (grant_id),
        .pop   (evt_pop),
        .rdata (evt_id),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (evt_count)
    );

    assign evt_valid = ~fifo_empty;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ats_alarm_event_queue.sv
// Directed bench for ats_alarm_event_queue with hand-computed expectations.
module tb_ats_alarm_event_queue;

    logic        clk;
    logic        reset;
    logic [23:0] alarm_finished;
    logic [23:0] alarm_mask;
    logic        evt_valid;
    logic [4:0]  evt_id;
    logic        evt_pop;
    logic [3:0]  evt_count;
    logic [23:0] pending;
    logic        overflow;
    logic        clr_overflow;

    int checks = 0;
    int errors = 0;

    ats_alarm_event_queue dut (
        .clk            (clk),
        .reset          (reset),
        .alarm_finished (alarm_finished),
        .alarm_mask     (alarm_mask),
        .evt_valid      (evt_valid),
        .evt_id         (evt_id),
        .evt_pop        (evt_pop),
        .evt_count      (evt_count),
        .pending        (pending),
        .overflow       (overflow),
        .clr_overflow   (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [23:0] fin, input logic [23:0] mask,
                                 input logic pop, input logic clr);
        alarm_finished = fin;
        alarm_mask     = mask;
        evt_pop        = pop;
        clr_overflow   = clr;
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    int drainIds[9] = '{1, 2, 3, 4, 5, 6, 7, 8, 3};
    int burstIds[3] = '{0, 7, 23};

    initial begin
        reset = 1'b0;
        alarm_finished = '0;
        alarm_mask = '0;
        evt_pop = 1'b0;
        clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("rst_count", 32'(evt_count), 32'd0);
        checkOutput("rst_pending", 32'(pending), 32'd0);
        checkOutput("rst_overflow", 32'(overflow), 32'd0);
        checkOutput("rst_id", 32'(evt_id), 32'd0);
        reset = 1'b1;
        repeat (3) nextCycle();

        // single edge on alarm 5
        applyStimulus(24'h000020, '0, 1'b0, 1'b0);
        checkOutput("single_pend_n", 32'(pending), 32'd0);
        nextCycle();
        applyStimulus(24'h000020, '0, 1'b0, 1'b0);
        checkOutput("single_pend_n1", 32'(pending), 32'h20);
        checkOutput("single_valid_n1", 32'(evt_valid), 32'd0);
        nextCycle();
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("single_valid_n2", 32'(evt_valid), 32'd1);
        checkOutput("single_id_n2", 32'(evt_id), 32'd5);
        checkOutput("single_pend_n2", 32'(pending), 32'd0);
        checkOutput("single_count_n2", 32'(evt_count), 32'd1);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("single_valid_pop", 32'(evt_valid), 32'd0);
        checkOutput("single_count_pop", 32'(evt_count), 32'd0);
        nextCycle();

        // burst of 23, 7, 0
        applyStimulus(24'h800081, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h800081, '0, 1'b0, 1'b0);
        checkOutput("burst_pend1", 32'(pending), 32'h800081);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("burst_id_first", 32'(evt_id), 32'd0);
        checkOutput("burst_pend2", 32'(pending), 32'h800080);
        checkOutput("burst_count1", 32'(evt_count), 32'd1);
        nextCycle();
        checkOutput("burst_pend3", 32'(pending), 32'h800000);
        checkOutput("burst_count2", 32'(evt_count), 32'd2);
        nextCycle();
        checkOutput("burst_pend4", 32'(pending), 32'd0);
        checkOutput("burst_count3", 32'(evt_count), 32'd3);
        for (int k = 0; k < 3; k++) begin
            applyStimulus('0, '0, 1'b1, 1'b0);
            checkOutput($sformatf("burst_pop_id%0d", k), 32'(evt_id), 32'(burstIds[k]));
            nextCycle();
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("burst_drained", 32'(evt_count), 32'd0);
        nextCycle();

        // nine alarms into an eight-deep FIFO
        applyStimulus(24'h0001FF, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h0001FF, '0, 1'b0, 1'b0);
        checkOutput("full_pend1", 32'(pending), 32'h1FF);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        repeat (7) nextCycle();
        checkOutput("full_count", 32'(evt_count), 32'd8);
        checkOutput("full_pend9", 32'(pending), 32'h100);
        checkOutput("full_head", 32'(evt_id), 32'd0);
        nextCycle();
        checkOutput("full_hold_count", 32'(evt_count), 32'd8);
        checkOutput("full_hold_pend", 32'(pending), 32'h100);
        applyStimulus('0, '0, 1'b1, 1'b0);
        checkOutput("full_pop_id", 32'(evt_id), 32'd0);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("full_after_pop_count", 32'(evt_count), 32'd8);
        checkOutput("full_after_pop_pend", 32'(pending), 32'd0);
        checkOutput("full_after_pop_id", 32'(evt_id), 32'd1);
        nextCycle();

        // repeat finish on alarm 3 while it waits behind a full FIFO
        applyStimulus(24'h000008, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("ovf_pend", 32'(pending), 32'h8);
        checkOutput("ovf_before", 32'(overflow), 32'd0);
        nextCycle();
        applyStimulus(24'h000008, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("ovf_set", 32'(overflow), 32'd1);
        checkOutput("ovf_pend_kept", 32'(pending), 32'h8);
        nextCycle();
        applyStimulus(24'h000008, '0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("ovf_set_wins", 32'(overflow), 32'd1);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b1);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("ovf_cleared", 32'(overflow), 32'd0);
        for (int k = 0; k < 9; k++) begin
            applyStimulus('0, '0, 1'b1, 1'b0);
            checkOutput($sformatf("drain_id%0d", k), 32'(evt_id), 32'(drainIds[k]));
            nextCycle();
        end
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("drain_valid", 32'(evt_valid), 32'd0);
        checkOutput("drain_count", 32'(evt_count), 32'd0);
        checkOutput("drain_pend", 32'(pending), 32'd0);
        nextCycle();

        // masked edge on alarm 2
        applyStimulus(24'h000004, 24'h000004, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h000004, 24'h000004, 1'b0, 1'b0);
        checkOutput("mask_pend", 32'(pending), 32'd0);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        checkOutput("mask_valid", 32'(evt_valid), 32'd0);
        nextCycle();

        // asynchronous reset with three events queued
        applyStimulus(24'h000070, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(24'h000070, '0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus('0, '0, 1'b0, 1'b0);
        repeat (2) nextCycle();
        checkOutput("pre_rst_count", 32'(evt_count), 32'd3);
        checkOutput("pre_rst_id", 32'(evt_id), 32'd4);
        #1;
        reset = 1'b0;
        #1;
        checkOutput("async_rst_valid", 32'(evt_valid), 32'd0);
        checkOutput("async_rst_count", 32'(evt_count), 32'd0);
        checkOutput("async_rst_id", 32'(evt_id), 32'd0);
        checkOutput("async_rst_pend", 32'(pending), 32'd0);
        checkOutput("async_rst_ovf", 32'(overflow), 32'd0);
        repeat (2) nextCycle();
        reset = 1'b1;
        repeat (3) nextCycle();
        checkOutput("post_rst_valid", 32'(evt_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
